bip_control_unit: RTL

- Instruction sequencer for the BIP accumulator datapath.
- Owns the program counter and instruction register, and fetches 16-bit instructions from a synchronous program ROM.
- Decodes opcode[15:11] and drives the datapath selects, write-enable and operation, plus the data-RAM read/write strobes.
- Sits between program ROM, data RAM and datapath inside the BIP top.

---
 rtl/bip_pkg.sv | 46 ++++
 rtl/bip_decoder.sv | 59 +++++
 rtl/bip_control_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared constants for the BIP control unit: opcodes, datapath selects, FSM encoding
// and the decoded control word.
package bip_pkg;

    localparam int PC_W    = 11;
    localparam int OPC_W   = 5;
    localparam int INSTR_W = OPC_W + PC_W;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic SEL_B_MEM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;
    localparam logic OP_ADD_OP = 1'b0;
    localparam logic OP_SUB_OP = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    // For memory instructions the word describes the write-back cycle; EXEC only reads.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       operation;
        logic       write_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       needs_wb;
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder producing the BIP control word; the sequencer masks
// it by state. Unlisted opcodes decode to an all-zero word (NOP).
module bip_decoder
    import bip_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPC_W
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctrl_t                   ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPCODE_WIDTH'(OP_HLT): ctrl.is_halt = 1'b1;
            OPCODE_WIDTH'(OP_STO): ctrl.wr_ram  = 1'b1;
            OPCODE_WIDTH'(OP_LD): begin
                ctrl.sel_a     = SEL_A_MEM;
                ctrl.write_acc = 1'b1;
                ctrl.rd_ram    = 1'b1;
                ctrl.needs_wb  = 1'b1;
            end
            OPCODE_WIDTH'(OP_LDI): begin
                ctrl.sel_a     = SEL_A_IMM;
                ctrl.write_acc = 1'b1;
            end
            OPCODE_WIDTH'(OP_ADD): begin
                ctrl.sel_a     = SEL_A_ALU;
                ctrl.sel_b     = SEL_B_MEM;
                ctrl.operation = OP_ADD_OP;
                ctrl.write_acc = 1'b1;
                ctrl.rd_ram    = 1'b1;
                ctrl.needs_wb  = 1'b1;
            end
            OPCODE_WIDTH'(OP_ADDI): begin
                ctrl.sel_a     = SEL_A_ALU;
                ctrl.sel_b     = SEL_B_IMM;
                ctrl.operation = OP_ADD_OP;
                ctrl.write_acc = 1'b1;
            end
            OPCODE_WIDTH'(OP_SUB): begin
                ctrl.sel_a     = SEL_A_ALU;
                ctrl.sel_b     = SEL_B_MEM;
                ctrl.operation = OP_SUB_OP;
                ctrl.write_acc = 1'b1;
                ctrl.rd_ram    = 1'b1;
                ctrl.needs_wb  = 1'b1;
            end
            OPCODE_WIDTH'(OP_SUBI): begin
                ctrl.sel_a     = SEL_A_ALU;
                ctrl.sel_b     = SEL_B_IMM;
                ctrl.operation = OP_SUB_OP;
                ctrl.write_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: PC, IR, fetch/latch/exec/write-back FSM and control outputs.
// Optional BIP_CYCLE_COUNTER_EN adds busy-cycle and retired-instruction counters.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_W,
    parameter int                  OPCODE_WIDTH = OPC_W,
    parameter int                  INSTR_WIDTH  = OPCODE_WIDTH + PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [INSTR_WIDTH-1:0] i_instruction,
    output logic [PC_WIDTH-1:0]    o_prog_addr,
    output logic [PC_WIDTH-1:0]    o_operand,
    output logic [1:0]             o_sel_a,
    output logic                   o_sel_b,
    output logic                   o_write_acc,
    output logic                   o_operation,
    output logic                   o_rd_ram,
    output logic                   o_wr_ram,
`ifdef BIP_CYCLE_COUNTER_EN
    output logic [31:0]            o_cycle_count,
    output logic [31:0]            o_instr_count,
`endif
    output logic                   o_busy,
    output logic                   o_halted
);

    logic [2:0]             state_reg, state_next;
    logic [PC_WIDTH-1:0]    pc_reg, pc_next;
    logic [INSTR_WIDTH-1:0] ir_reg, ir_next;
    ctrl_t                  dec_ctrl;
    logic                   busy_int;
    logic                   retire_int;

    bip_decoder #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_decoder (
        .opcode(ir_reg[INSTR_WIDTH-1 -: OPCODE_WIDTH]),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_IDLE:  if (i_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: begin
                ir_next    = i_instruction;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_ctrl.is_halt) begin
                    state_next = ST_HALT;
                end else if (dec_ctrl.needs_wb) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_FETCH;
                    pc_next    = pc_reg + PC_WIDTH'(1);
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                pc_next    = pc_reg + PC_WIDTH'(1);
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // Controls are gated by rst so an in-flight write-back is suppressed in the reset cycle.
    always_comb begin
        o_sel_a     = '0;
        o_sel_b     = 1'b0;
        o_operation = 1'b0;
        o_write_acc = 1'b0;
        o_rd_ram    = 1'b0;
        o_wr_ram    = 1'b0;
        if (rst) begin
            case (state_reg)
                ST_EXEC: begin
                    if (dec_ctrl.needs_wb) begin
                        o_rd_ram = 1'b1;
                    end else begin
                        o_sel_a     = dec_ctrl.sel_a;
                        o_sel_b     = dec_ctrl.sel_b;
                        o_operation = dec_ctrl.operation;
                        o_write_acc = dec_ctrl.write_acc;
                        o_wr_ram    = dec_ctrl.wr_ram;
                    end
                end
                ST_WB: begin
                    o_sel_a     = dec_ctrl.sel_a;
                    o_sel_b     = dec_ctrl.sel_b;
                    o_operation = dec_ctrl.operation;
                    o_write_acc = dec_ctrl.write_acc;
                    o_rd_ram    = dec_ctrl.rd_ram;
                end
                default: ;
            endcase
        end
    end

    assign busy_int    = (state_reg == ST_FETCH) || (state_reg == ST_LATCH) ||
                         (state_reg == ST_EXEC)  || (state_reg == ST_WB);
    // An instruction retires when leaving EXEC without write-back (incl. HLT) or leaving WB.
    assign retire_int  = ((state_reg == ST_EXEC) && !dec_ctrl.needs_wb) ||
                         (state_reg == ST_WB);

    assign o_busy      = rst & busy_int;
    assign o_halted    = rst & (state_reg == ST_HALT);
    assign o_prog_addr = pc_reg;
    assign o_operand   = ir_reg[PC_WIDTH-1:0];

`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] cycle_count_reg;
    logic [31:0] instr_count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            if (busy_int)   cycle_count_reg <= cycle_count_reg + 32'd1;
            if (retire_int) instr_count_reg <= instr_count_reg + 32'd1;
        end
    end

    assign o_cycle_count = cycle_count_reg;
    assign o_instr_count = instr_count_reg;
`else
    logic unused_retire;
    assign unused_retire = retire_int;
`endif

endmodule
